// File: rtl/cache_types_pkg.sv
// Shared cache-side types and line/beat geometry for the line burst adapter.
// Imported by the adapter interface, the line buffer and the adapter top.
package cache_types_pkg;

  localparam int S_OFFSET       = 5;
  localparam int LINE_BITS      = 8 * (2 ** S_OFFSET);
  localparam int BEAT_BITS      = 64;
  localparam int BEATS_PER_LINE = LINE_BITS / BEAT_BITS;
  localparam int BEAT_IDX_BITS  = $clog2(BEATS_PER_LINE);

  typedef logic [LINE_BITS-1:0]     line_t;
  typedef logic [BEAT_BITS-1:0]     beat_t;
  typedef logic [BEAT_IDX_BITS-1:0] beat_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } adapter_state_t;

  // Clears the byte-offset bits so the burst always starts on a line boundary.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~((32'd1 << S_OFFSET) - 32'd1);
  endfunction

endpackage

// File: rtl/line_burst_adapter_if.sv
// Cache-line request bus (pmem_*) and downstream burst bus (burst_*) bundled together.
// The adapter uses the slave view; the cache plus burst memory side uses the master view.
interface line_burst_adapter_if;
  import cache_types_pkg::*;

  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_addr;
  line_t       pmem_wdata;
  line_t       pmem_rdata;
  logic        pmem_resp;

  logic        burst_read;
  logic        burst_write;
  logic [31:0] burst_addr;
  beat_t       burst_wdata;
  beat_t       burst_rdata;
  logic        burst_resp;

  modport slave (
    input  pmem_read, pmem_write, pmem_addr, pmem_wdata,
    output pmem_rdata, pmem_resp,
    output burst_read, burst_write, burst_addr, burst_wdata,
    input  burst_rdata, burst_resp
  );

  modport master (
    output pmem_read, pmem_write, pmem_addr, pmem_wdata,
    input  pmem_rdata, pmem_resp,
    input  burst_read, burst_write, burst_addr, burst_wdata,
    output burst_rdata, burst_resp
  );

endinterface

// File: rtl/line_burst_adapter_line_shift_buffer.sv
// 256-bit line buffer: whole-line load, one beat-indexed 64-bit write port and a beat read mux.
// o_line_next exposes the value being written this cycle so the final read beat can be forwarded.
module line_shift_buffer
  import cache_types_pkg::*;
(
  input  logic      clk,
  input  logic      i_load,
  input  line_t     i_load_line,
  input  logic      i_beat_we,
  input  beat_idx_t i_beat_idx,
  input  beat_t     i_beat_wdata,
  output beat_t     o_beat_rdata,
  output line_t     o_line_next
);

  line_t r_line;
  line_t w_line_next;

  // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_line_next = r_line;
    if (i_load) begin
      w_line_next = i_load_line;
    end else if (i_beat_we) begin
      w_line_next[i_beat_idx*BEAT_BITS +: BEAT_BITS] = i_beat_wdata;
    end
  end

  // NOTE: pure data storage carries no reset; the adapter gates every output that reads it.
  always_ff @(posedge clk) begin
    r_line <= w_line_next;
  end

  assign o_beat_rdata = r_line[i_beat_idx*BEAT_BITS +: BEAT_BITS];
  assign o_line_next  = w_line_next;

endmodule

// File: rtl/line_burst_adapter.sv
// Serialises 256-bit cache-line reads/writes into 4-beat 64-bit bursts with a one-cycle pmem_resp.
// Define LINE_BURST_PERF_EN to build the read/write completion counters; otherwise they read 0.
module line_burst_adapter
  import cache_types_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  line_burst_adapter_if.slave bus,
  output logic [31:0]         write_count,
  output logic [31:0]         read_count
);

  adapter_state_t r_state;
  adapter_state_t w_state_next;
  logic [31:0]    r_addr;
  beat_idx_t      r_beat;
  line_t          r_rdata;

  logic  w_accept;
  logic  w_in_burst;
  logic  w_beat_done;
  logic  w_last_beat;
  beat_t w_beat_rdata;
  line_t w_line_next;

  assign w_accept    = (r_state == IDLE) && (bus.pmem_read || bus.pmem_write);
  assign w_in_burst  = (r_state == READ) || (r_state == WRITE);
  assign w_beat_done = w_in_burst && bus.burst_resp;
  assign w_last_beat = (r_beat == beat_idx_t'(BEATS_PER_LINE - 1));

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.pmem_write) begin
          w_state_next = WRITE;
        end else if (bus.pmem_read) begin
          w_state_next = READ;
        end
      end
      READ, WRITE: begin
        if (bus.burst_resp && w_last_beat) begin
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Burst address and data are forced to 0 outside a burst so reset clears every output.
  always_comb begin
    bus.burst_read  = 1'b0;
    bus.burst_write = 1'b0;
    bus.burst_addr  = '0;
    bus.burst_wdata = '0;
    bus.pmem_resp   = 1'b0;
    case (r_state)
      READ: begin
        bus.burst_read = 1'b1;
        bus.burst_addr = r_addr;
      end
      WRITE: begin
        bus.burst_write = 1'b1;
        bus.burst_addr  = r_addr;
        bus.burst_wdata = w_beat_rdata;
      end
      RESP:    bus.pmem_resp = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_beat <= '0;
    end else if (w_accept) begin
      r_addr <= line_align(bus.pmem_addr);
      r_beat <= '0;
    end else if (w_beat_done) begin
      r_beat <= r_beat + beat_idx_t'(1);
    end
  end

  // The last read beat lands in the buffer on the same edge, so take the forwarded line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if ((r_state == READ) && bus.burst_resp && w_last_beat) begin
      r_rdata <= w_line_next;
    end
  end

  assign bus.pmem_rdata = r_rdata;

  line_shift_buffer u_line_buf (
    .clk          (clk),
    .i_load       (w_accept),
    .i_load_line  (bus.pmem_wdata),
    .i_beat_we    ((r_state == READ) && bus.burst_resp),
    .i_beat_idx   (r_beat),
    .i_beat_wdata (bus.burst_rdata),
    .o_beat_rdata (w_beat_rdata),
    .o_line_next  (w_line_next)
  );

`ifdef LINE_BURST_PERF_EN
  logic        r_is_write;
  logic [31:0] r_write_count;
  logic [31:0] r_read_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_write    <= 1'b0;
      r_write_count <= '0;
      r_read_count  <= '0;
    end else begin
      if (w_accept) begin
        r_is_write <= bus.pmem_write;
      end
      if (r_state == RESP) begin
        if (r_is_write) begin
          r_write_count <= r_write_count + 32'd1;
        end else begin
          r_read_count <= r_read_count + 32'd1;
        end
      end
    end
  end

  assign write_count = r_write_count;
  assign read_count  = r_read_count;
`else
  assign write_count = '0;
  assign read_count  = '0;
`endif

endmodule

// File: doc/line_burst_adapter.md
Name: line_burst_adapter

Overview:
- Responder end of the cache-line memory interface that the L1 data/instruction caches use as initiator.
- Accepts a full 256-bit line read or write with a single-pulse completion response.
- Serialises each request into a fixed 4-beat, 64-bit burst on the downstream physical-memory bus.
- Sits between the L1 cache (or L2 arbiter output) and the burst DRAM model.

Parameters:
s_offset, 5, line offset bits; line = 2**s_offset bytes
s_line, 8*2**s_offset, line width in bits (256)
beat_width, 64, downstream beat width in bits
num_beats, s_line/beat_width, beats per line (4)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
pmem_read  input  1  line read request; held until pmem_resp
pmem_write  input  1  line write request; held until pmem_resp
pmem_addr  input  32  request address; low s_offset bits ignored
pmem_wdata  input  s_line  write line
pmem_rdata  output  s_line  read line; valid in the pmem_resp cycle, then held
pmem_resp  output  1  one-cycle completion pulse
burst_read  output  1  downstream read burst; held for the whole burst
burst_write  output  1  downstream write burst; held for the whole burst
burst_addr  output  32  line-aligned burst address
burst_wdata  output  beat_width  current write beat
burst_rdata  input  beat_width  current read beat
burst_resp  input  1  per-beat acknowledge
write_count  output  32  completed line writes (see Optional Feature)
read_count  output  32  completed line reads (see Optional Feature)

Behaviour:
- Reset values:
  - All outputs are 0, including pmem_rdata and the counters.
  - State is IDLE and the beat counter is 0.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - Samples requests only in this state.
  - pmem_write=1 → WRITE. pmem_write has priority when both requests are asserted; the read is not serviced.
  - pmem_read=1 (and no write) → READ.
  - On acceptance, in the same edge:
    - Capture {pmem_addr[31:s_offset], s_offset'b0} into the address register.
    - Capture pmem_wdata into the line buffer.
    - Clear the beat counter.
- READ:
  - burst_read=1 and burst_addr = captured address.
  - On each burst_resp, burst_rdata is stored into line buffer bits [beat*64 +: 64]; beat 0 is the low word. The beat counter then increments.
  - On burst_resp at beat num_beats-1 → RESP. burst_read drops on the following cycle.
- WRITE:
  - burst_write=1 and burst_wdata = line buffer [beat*64 +: 64], taken from the captured data.
  - The beat advances on burst_resp; on the last beat's burst_resp → RESP.
- RESP:
  - pmem_resp=1 for exactly one cycle, then → IDLE.
  - For reads, pmem_rdata = assembled line, registered from the line buffer.
- Latency: a request accepted at edge N, with downstream responses on consecutive cycles, gives pmem_resp at cycle N+5.
- Back-to-back requests:
  - The initiator drops its request in the cycle after pmem_resp.
  - The adapter re-samples in IDLE, so a held request is never serviced twice. A new request is accepted at the earliest one cycle after RESP.
- burst_resp outside READ/WRITE is ignored.
- The beat counter is log2(num_beats) bits and wraps naturally after the last beat.
- pmem_rdata is held between reads. A write does not disturb the pmem_rdata output register.
- Reset mid-burst:
  - Return to IDLE immediately, with no pmem_resp.
  - The downstream memory shares the same reset and abandons the burst.
- Counters:
  - Increment in RESP: write_count for writes, read_count for reads.
  - 32-bit, wrap at 2^32.

Optional Feature:
- Macro LINE_BURST_PERF_EN.
- Defined: read_count and write_count are live as described. They feed the memory-mapped performance counter block alongside ewb_writes.
- Undefined: the counter registers are not built, and both ports are tied to constant 0.

Decomposition:
- Shared package cache_types_pkg holds:
  - State enum adapter_state_t {IDLE, READ, WRITE, RESP}.
  - Constants LINE_BITS=256, BEAT_BITS=64, BEATS_PER_LINE=4.
- One natural sub-module, line_shift_buffer: the 256-bit line buffer with a beat-indexed 64-bit write port and a beat-indexed read mux.
- The FSM and counters stay in the top module.

Test Plan:
- Read, 0-wait memory:
  - Stimulus: pmem_read, addr 0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Response: burst_addr=0x0000_1220; pmem_rdata={0x44..44,0x33..33,0x22..22,0x11..11}; pmem_resp a single pulse 5 cycles after acceptance.
- Write with stalls:
  - Stimulus: pmem_write, addr 0x8000_0040, line word i = i; burst_resp delayed 3 cycles per beat.
  - Response: burst_wdata sequence {1,0}, {3,2}, {5,4}, {7,6} (32-bit words); burst_write held throughout; one pmem_resp.
- Simultaneous read+write in IDLE:
  - Response: WRITE is serviced, burst_read never asserts, write_count=1 and read_count=0 (with LINE_BURST_PERF_EN).
- Back-to-back write then read (eviction then allocate):
  - Response: two distinct bursts separated by at least 1 IDLE cycle, two pmem_resp pulses, no duplicate burst.
- Reset asserted after the 2nd read beat:
  - Response: all outputs 0 asynchronously, no pmem_resp.
  - A subsequent read completes normally with correct data.
- Macro off:
  - Response: after 3 reads, read_count and write_count read 0.
